lane_traffic_ctrl: RTL

Parametrised traffic generator for the road section of the game board. It drives NUM_LANES lanes with CARS_PER_LANE cars each, and each lane has its own direction and step period. Difficulty scaling comes from i_Level, and i_Enable provides a pause. The block also reports a registered frog/car collision. It sits between the game-state FSM, which supplies level, pause and frog position, and the tile renderer, which consumes the flattened car positions.

---
 rtl/lane_traffic_ctrl_pkg.sv | 23 ++
 rtl/lane_traffic_ctrl_if.sv | 26 ++
 rtl/lane_traffic_ctrl_tick_prescaler.sv | 23 ++
 rtl/lane_traffic_ctrl.sv | 76 +++++++
 4 files changed

// File: rtl/lane_traffic_ctrl_pkg.sv
// traffic_pkg: shared widths and constant helpers for the road-lane traffic generator.
package traffic_pkg;
    localparam int POS_W    = 5;
    localparam int PERIOD_W = 4;
    localparam int DIR_W    = 1;

    // Cars start evenly spread, staggered by one column per lane
    function automatic int init_x(int lane, int car, int max_x, int cars_per_lane);
        return (car * ((max_x + 1) / cars_per_lane) + lane) % (max_x + 1);
    endfunction

    function automatic int car_idx(int lane, int car, int cars_per_lane);
        return lane * cars_per_lane + car;
    endfunction

    function automatic int lane_of(int c, int cars_per_lane);
        return c / cars_per_lane;
    endfunction

    function automatic int car_of(int c, int cars_per_lane);
        return c % cars_per_lane;
    endfunction
endpackage

// File: rtl/lane_traffic_ctrl_if.sv
// lane_traffic_ctrl_if: game-side controls in, flattened car positions and flags out.
interface lane_traffic_ctrl_if #(
    parameter int NUM_LANES     = 8,
    parameter int CARS_PER_LANE = 2,
    parameter int POS_W         = traffic_pkg::POS_W,
    parameter int LEVEL_W       = 3
);
    localparam int CAR_W = NUM_LANES * CARS_PER_LANE * POS_W;
    logic               i_Enable;
    logic [LEVEL_W-1:0] i_Level;
    logic [POS_W-1:0]   i_Frog_X;
    logic [POS_W-1:0]   i_Frog_Y;
    logic [CAR_W-1:0]   o_Car_X;
    logic [CAR_W-1:0]   o_Car_Y;
    logic               o_Step;
    logic               o_Hit;

    modport master (
        output i_Enable, i_Level, i_Frog_X, i_Frog_Y,
        input  o_Car_X, o_Car_Y, o_Step, o_Hit
    );
    modport slave (
        input  i_Enable, i_Level, i_Frog_X, i_Frog_Y,
        output o_Car_X, o_Car_Y, o_Step, o_Hit
    );
endinterface

// File: rtl/lane_traffic_ctrl_tick_prescaler.sv
// tick_prescaler: free-running 0..COUNT-1 counter that pauses with i_Enable and pulses o_Tick on wrap.
module tick_prescaler #(
    parameter int COUNT = 700000,
    parameter int WIDTH = 21
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Enable,
    output logic o_Tick
);
    logic [WIDTH-1:0] count_q, count_d;

    assign o_Tick = i_Enable && count_q == WIDTH'(COUNT - 1);

    always_comb begin
        count_d = !i_Enable ? count_q : o_Tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) count_q <= '0;
        else         count_q <= count_d;
    end
endmodule

// File: rtl/lane_traffic_ctrl.sv
// lane_traffic_ctrl: per-lane car movement with level-scaled periods, step pulse and registered frog hit.
module lane_traffic_ctrl import traffic_pkg::*; #(
    parameter int                            NUM_LANES     = 8,
    parameter int                            CARS_PER_LANE = 2,
    parameter int                            POS_W         = 5,
    parameter int                            c_MAX_X       = 19,
    parameter int                            c_LANE_Y0     = 1,
    parameter int                            c_TICK_COUNT  = 700000,
    parameter int                            TICK_W        = 21,
    parameter logic [NUM_LANES*PERIOD_W-1:0] c_LANE_PERIOD = {NUM_LANES{4'd1}},
    parameter logic [NUM_LANES*DIR_W-1:0]    c_LANE_DIR    = 8'b10101010,
    parameter int                            LEVEL_W       = 3
) (
    input logic                i_Clk,
    input logic                i_Reset,
    lane_traffic_ctrl_if.slave bus
);
    localparam int               NUM_CARS = NUM_LANES * CARS_PER_LANE;
    localparam int               CW       = (LEVEL_W > PERIOD_W ? LEVEL_W : PERIOD_W) + 1;
    localparam logic [POS_W-1:0] MAX_X    = POS_W'(c_MAX_X);

    logic                 tick;
    logic [CW-1:0]        lvl;
    logic [NUM_LANES-1:0] lane_step;
    logic [NUM_CARS-1:0]  car_hit;
    logic [PERIOD_W-1:0]  cnt_q [NUM_LANES];
    logic [PERIOD_W-1:0]  cnt_d [NUM_LANES];
    logic [POS_W-1:0]     x_q [NUM_CARS];
    logic [POS_W-1:0]     x_d [NUM_CARS];
    logic                 step_q, hit_q;

    tick_prescaler #(.COUNT(c_TICK_COUNT), .WIDTH(TICK_W)) u_prescaler (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Enable (bus.i_Enable),
        .o_Tick   (tick)
    );

    assign lvl        = CW'(bus.i_Level);
    assign bus.o_Step = step_q;
    assign bus.o_Hit  = hit_q;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        localparam logic [CW-1:0]    PER = CW'(c_LANE_PERIOD[l*PERIOD_W +: PERIOD_W]);
        localparam logic [POS_W-1:0] Y   = POS_W'(c_LANE_Y0 + l);
        logic [CW-1:0] eff;
        // A zero period freezes the lane; otherwise level shortens it down to one tick
        assign eff          = PER > lvl ? PER - lvl : CW'(1);
        assign lane_step[l] = tick && PER != '0 && CW'(cnt_q[l]) + CW'(1) >= eff;
        assign cnt_d[l]     = lane_step[l] ? '0 : (tick && PER != '0) ? cnt_q[l] + 1'b1 : cnt_q[l];
        for (genvar k = 0; k < CARS_PER_LANE; k++) begin : g_car
            localparam int C = car_idx(l, k, CARS_PER_LANE);
            assign x_d[C] = !lane_step[l] ? x_q[C] :
                            c_LANE_DIR[l] ? (x_q[C] == MAX_X ? '0 : x_q[C] + 1'b1) :
                                            (x_q[C] == '0 ? MAX_X : x_q[C] - 1'b1);
            assign car_hit[C]                    = x_q[C] == bus.i_Frog_X && Y == bus.i_Frog_Y;
            assign bus.o_Car_X[C*POS_W +: POS_W] = x_q[C];
            assign bus.o_Car_Y[C*POS_W +: POS_W] = Y;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            for (int l = 0; l < NUM_LANES; l++) cnt_q[l] <= '0;
            for (int c = 0; c < NUM_CARS; c++)
                x_q[c] <= POS_W'(init_x(lane_of(c, CARS_PER_LANE), car_of(c, CARS_PER_LANE), c_MAX_X, CARS_PER_LANE));
            step_q <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            x_q    <= x_d;
            step_q <= |lane_step;
            hit_q  <= |car_hit;
        end
    end
endmodule
